// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arbiter_pkg;

    localparam int unsigned DARB_ADDR_W = 9;
    localparam int unsigned DARB_DATA_W = 16;

    typedef enum logic [1:0] {
        DARB_IDLE  = 2'd0,
        DARB_ISSUE = 2'd1,
        DARB_DONE  = 2'd2
    } darb_state_e;

    localparam logic DARB_P0 = 1'b0;
    localparam logic DARB_P1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter_pick.sv
// Combinational 2-way picker. DMEM_ARB_RR_EN selects round-robin; otherwise port 0 has fixed priority.
module dmem_arb_pick
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_winner_i,
    output logic       gnt_valid_o,
    output logic       gnt_id_o
);

    always_comb begin
        gnt_valid_o = |req_i;
        gnt_id_o    = DARB_P0;
`ifdef DMEM_ARB_RR_EN
        if (&req_i) begin
            gnt_id_o = ~last_winner_i;
        end else if (req_i[1]) begin
            gnt_id_o = DARB_P1;
        end
`else
        if (!req_i[0] && req_i[1]) begin
            gnt_id_o = DARB_P1;
        end
`endif
    end

`ifndef DMEM_ARB_RR_EN
    logic unused_last_winner;
    assign unused_last_winner = last_winner_i;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a single-port data memory between a CPU port (p0) and a DMA/debug port (p1).
// Optional round-robin arbitration is enabled with macro DMEM_ARB_RR_EN.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DARB_ADDR_W,
    parameter int unsigned DATA_W = DARB_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    darb_state_e       state_q, state_d;
    logic              cmd_id_q, cmd_id_d;
    logic              cmd_we_q, cmd_we_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
    logic              p0_ack_q, p0_ack_d;
    logic              p1_ack_q, p1_ack_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              last_winner;
    logic              gnt_valid;
    logic              gnt_id;
    logic              sel_we;

`ifdef DMEM_ARB_RR_EN
    logic last_winner_q, last_winner_d;
    assign last_winner = last_winner_q;
`else
    assign last_winner = DARB_P1;
`endif

    dmem_arb_pick u_pick (
        .req_i         ({p1_req, p0_req}),
        .last_winner_i (last_winner),
        .gnt_valid_o   (gnt_valid),
        .gnt_id_o      (gnt_id)
    );

    assign sel_we = (gnt_id == DARB_P1) ? p1_we : p0_we;

    always_comb begin
        state_d     = state_q;
        cmd_id_d    = cmd_id_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        p0_rdata_d  = p0_rdata_q;
        p1_rdata_d  = p1_rdata_q;
        p0_ack_d    = 1'b0;
        p1_ack_d    = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
`ifdef DMEM_ARB_RR_EN
        last_winner_d = last_winner_q;
`endif
        case (state_q)
            DARB_IDLE: begin
                if (gnt_valid) begin
                    state_d     = DARB_ISSUE;
                    cmd_id_d    = gnt_id;
                    cmd_we_d    = sel_we;
                    cmd_addr_d  = (gnt_id == DARB_P1) ? p1_addr  : p0_addr;
                    cmd_wdata_d = (gnt_id == DARB_P1) ? p1_wdata : p0_wdata;
                    // Strobes are registered here so they are live for the whole ISSUE cycle.
                    mem_write_d = sel_we;
                    mem_read_d  = ~sel_we;
`ifdef DMEM_ARB_RR_EN
                    last_winner_d = gnt_id;
`endif
                end
            end
            DARB_ISSUE: begin
                state_d = DARB_DONE;
                if (!cmd_we_q) begin
                    if (cmd_id_q == DARB_P1) p1_rdata_d = mem_rdata;
                    else                     p0_rdata_d = mem_rdata;
                end
                p0_ack_d = (cmd_id_q == DARB_P0);
                p1_ack_d = (cmd_id_q == DARB_P1);
            end
            DARB_DONE: begin
                state_d = DARB_IDLE;
            end
            default: begin
                state_d = DARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= DARB_IDLE;
            cmd_id_q    <= DARB_P0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
            p0_ack_q    <= 1'b0;
            p1_ack_q    <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            last_winner_q <= DARB_P1;
`endif
        end else begin
            state_q     <= state_d;
            cmd_id_q    <= cmd_id_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
            p0_ack_q    <= p0_ack_d;
            p1_ack_q    <= p1_ack_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
`ifdef DMEM_ARB_RR_EN
            last_winner_q <= last_winner_d;
`endif
        end
    end

    assign p0_ack    = p0_ack_q;
    assign p1_ack    = p1_ack_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign mem_read  = mem_read_q;
    // A reset arriving during ISSUE must not let the pending write land in memory.
    assign mem_write = mem_write_q & ~rst;
    assign mem_addr  = cmd_addr_q;
    assign mem_wdata = cmd_wdata_q;

endmodule
